// File: rtl/seq_divider.sv
// fulladd: one-bit full adder cell, the building block of the divider's trial subtractor.
// Ports: a_i/b_i operand bits, c_i carry-in; s_o sum, c_o carry-out.
// Purely combinational, no clock or reset.
module fulladd (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// seq_divider: unsigned restoring divider, one quotient bit per clock, WIDTH steps per division.
// Ports: clk_i/reset_i (async, active-high); start_i with dividend_i/divisor_i; busy_o (RUN),
// done_o (one-cycle DONE pulse), quotient_o/remainder_o/div_by_zero_o held until the next result.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]  dvs_q, dvs_d;     // latched divisor
    logic [WIDTH-1:0]  rem_q, rem_d;     // partial remainder
    logic [CW-1:0]     cnt_q, cnt_d;     // iteration counter
    logic [WIDTH-1:0]  quo_q, quo_d;     // published quotient
    logic [WIDTH-1:0]  rmd_q, rmd_d;     // published remainder
    logic              dbz_q, dbz_d;     // published divide-by-zero flag

    // ---------------------------------------------------------------
    // One restoring step: {rem, next dividend bit} - divisor, computed
    // as a + ~b + 1 over WIDTH+1 bits. Carry-out 1 means no borrow.
    // ---------------------------------------------------------------
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] carry;
    logic             no_borrow;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    assign shifted  = {rem_q, dvd_q[WIDTH-1]};
    assign sub_b    = ~{1'b0, dvs_q};
    assign carry[0] = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        fulladd u_fa (
            .a_i (shifted[i]),
            .b_i (sub_b[i]),
            .c_i (carry[i]),
            .s_o (diff[i]),
            .c_o (carry[i+1])
        );
    end

    assign no_borrow = carry[WIDTH+1];
    // The partial remainder stays below the divisor, so the top bit of
    // either candidate is always zero and only WIDTH bits are kept.
    assign step_rem  = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_quo  = {dvd_q[WIDTH-2:0], no_borrow};

    logic unused_top_bits;
    assign unused_top_bits = diff[WIDTH] ^ shifted[WIDTH];

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    // ---------------------------------------------------------------
    // Next state. Published results only change on entry to DONE, so
    // they are stable throughout RUN and IDLE.
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        case (state_q)
            RUN: begin
                // start is deliberately not looked at here
                dvd_d = step_quo;
                rem_d = step_rem;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    quo_d   = step_quo;
                    rmd_d   = step_rem;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // IDLE or DONE: DONE lasts one cycle unless a new start lands
                state_d = IDLE;
                if (start_i) begin
                    dvd_d = dividend_i;
                    dvs_d = divisor_i;
                    rem_d = '0;
                    cnt_d = '0;
                    if (divisor_i == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = dividend_i;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
        endcase
    end

    assign busy_o        = (state_q == RUN);
    assign done_o        = (state_q == DONE);
    assign quotient_o    = quo_q;
    assign remainder_o   = rmd_q;
    assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive a start at the current negedge (call from a negedge).
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
    endtask

    // From the negedge where start was driven, count negedges until done.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int lat, bn;
        @(negedge clk);
        drive_start(a, b);
        wait_done(lat, bn);
        check({tag, " latency"}, lat, (b == 0) ? 1 : W + 1);
        check({tag, " busy cycles"}, bn, (b == 0) ? 0 : W);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, div_by_zero, ez);
    endtask

    initial begin
        int lat, bn, seen;
        logic [W-1:0] ra, rb, mq, mr;

        vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        vecs[3]  = '{8'd37,  8'd0,   8'd255, 8'd37,  1'b1};
        vecs[4]  = '{8'd200, 8'd3,   8'd66,  8'd2,   1'b0};
        vecs[5]  = '{8'd9,   8'd4,   8'd2,   8'd1,   1'b0};
        vecs[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        vecs[7]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[8]  = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
        vecs[9]  = '{8'd254, 8'd16,  8'd15,  8'd14,  1'b0};
        vecs[10] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
        vecs[11] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Table vectors; done must be a single-cycle pulse and results must hold in IDLE.
        foreach (vecs[i]) begin
            run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
            @(negedge clk);
            check($sformatf("vec%0d done pulse width", i), done, 0);
            @(negedge clk);
            check($sformatf("vec%0d idle hold q", i), quotient, vecs[i].q);
            check($sformatf("vec%0d idle hold r", i), remainder, vecs[i].r);
        end
        // last table result was 1/255 -> q=0, r=1

        // Start during RUN is ignored; start in the DONE cycle is accepted.
        @(negedge clk);
        drive_start(8'd100, 8'd7);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        drive_start(8'd200, 8'd3);
        @(negedge clk);
        start = 1'b0;
        check("run-start busy", busy, 1);
        check("run-start q stable", quotient, 0);
        check("run-start r stable", remainder, 1);
        lat = 0;
        for (int i = 5; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check("ignored start latency", lat, W + 1);
        check("ignored start quotient", quotient, 14);
        check("ignored start remainder", remainder, 2);
        drive_start(8'd200, 8'd3);
        wait_done(lat, bn);
        check("done-cycle start latency", lat, W + 1);
        check("done-cycle start busy", bn, W);
        check("done-cycle start quotient", quotient, 66);
        check("done-cycle start remainder", remainder, 2);

        // Asynchronous reset in the middle of RUN aborts the division.
        @(negedge clk);
        drive_start(8'd100, 8'd7);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        check("mid-run reset busy", busy, 0);
        check("mid-run reset done", done, 0);
        check("mid-run reset quotient", quotient, 0);
        check("mid-run reset remainder", remainder, 0);
        check("mid-run reset div_by_zero", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no done after abort", seen, 0);

        // start present on the first edge after reset release
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive_start(8'd9, 8'd4);
        wait_done(lat, bn);
        check("post-reset latency", lat, W + 1);
        check("post-reset quotient", quotient, 2);
        check("post-reset remainder", remainder, 1);

        // Random sweep with corner operands mixed in.
        for (int n = 0; n < 1000; n++) begin
            case (n % 10)
                0:       ra = 8'd0;
                1:       ra = 8'd255;
                default: ra = W'($urandom_range(0, 255));
            endcase
            case (n % 7)
                0:       rb = 8'd0;
                1:       rb = 8'd255;
                default: rb = W'($urandom_range(0, 255));
            endcase
            if (rb == 0) begin
                mq = '1;
                mr = ra;
            end else begin
                mq = ra / rb;
                mr = ra % rb;
            end
            run_one($sformatf("rand%0d %0d/%0d", n, ra, rb), ra, rb, mq, mr, rb == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
